// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter
//
// Collects asynchronous interrupt request lines into a pending register and
// presents the highest-priority eligible channel (lowest index wins) to a
// single consumer. The consumer claims the presented ID and later completes
// it. One channel is in service at a time.
//
// Ports:
//   CLK                 single rising-edge clock
//   rst                 asynchronous active-high reset
//   interrupt_requests  raw asynchronous request lines, one per channel
//   interrupt_masks     1 = channel masked (pending still collected)
//   interrupt_edge_mode 1 = rising-edge sensitive, 0 = level-high
//   claim               strobe: accept the presented irq_id
//   complete            strobe: end service of complete_id
//   complete_id         ID being completed
//   irq_out             registered "eligible interrupt presented"
//   irq_id              registered highest-priority eligible ID
//   busy                high while a channel is in service (this is the FSM state)
//   claimed_id          ID currently (or most recently) in service
//   pending             raw pending register, before masking
//   complete_err        one-cycle pulse on a complete that does not match
//
// Handshake: claim is accepted only when the arbiter is idle and irq_out is
// high; claim in any other situation is ignored. complete is accepted only in
// service with complete_id equal to claimed_id; every other complete produces
// a complete_err pulse and changes nothing. Both strobes are judged against
// the state at the edge that samples them, so a same-cycle claim+complete
// never chains.

module irq_pending_arbiter #(
    parameter int N_interrupts = 32,
    parameter int SYNC_STAGES  = 2,
    localparam int ID_W        = $clog2(N_interrupts)
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic [N_interrupts-1:0] interrupt_requests,
    input  logic [N_interrupts-1:0] interrupt_masks,
    input  logic [N_interrupts-1:0] interrupt_edge_mode,
    input  logic                    claim,
    input  logic                    complete,
    input  logic [ID_W-1:0]         complete_id,
    output logic                    irq_out,
    output logic [ID_W-1:0]         irq_id,
    output logic                    busy,
    output logic [ID_W-1:0]         claimed_id,
    output logic [N_interrupts-1:0] pending,
    output logic                    complete_err
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    state_t                  r_state;
    logic [N_interrupts-1:0] r_sync [SYNC_STAGES];
    logic [N_interrupts-1:0] r_prev;
    logic [N_interrupts-1:0] r_pending;

    logic [N_interrupts-1:0] w_sync;
    logic [N_interrupts-1:0] w_in_service;
    logic [N_interrupts-1:0] w_clear;
    logic [N_interrupts-1:0] w_set;
    logic [N_interrupts-1:0] w_eligible;
    logic                    w_claim_ok;
    logic                    w_complete_ok;
    logic                    w_any;
    logic [ID_W-1:0]         w_enc;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign pending = r_pending;

    // Synchronizer chain plus one extra flop for edge detection. prev resets
    // to 0 as well, so a line held high through reset yields exactly one edge
    // once the chain has filled.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= interrupt_requests;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= w_sync;
        end
    end

    always_comb begin
        w_claim_ok    = (r_state == ST_IDLE) && claim && irq_out;
        w_complete_ok = (r_state == ST_SERVICE) && complete && (complete_id == claimed_id);
    end

    // A channel counts as in service both while SERVICE holds it and in the
    // very cycle its claim is accepted; otherwise a held level request would
    // immediately re-set the bit the claim is clearing.
    always_comb begin
        w_in_service = '0;
        w_clear      = '0;
        for (int i = 0; i < N_interrupts; i++) begin
            w_in_service[i] = ((r_state == ST_SERVICE) && (claimed_id == ID_W'(i)))
                              || (w_claim_ok && (irq_id == ID_W'(i)));
            w_clear[i]      = w_claim_ok && (irq_id == ID_W'(i));
        end
    end

    always_comb begin
        w_set = (w_sync & ~r_prev & interrupt_edge_mode)
              | (w_sync & ~w_in_service & ~interrupt_edge_mode);
    end

    // Lowest index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        w_eligible = r_pending & ~interrupt_masks;
        w_any      = |w_eligible;
        w_enc      = '0;
        for (int i = N_interrupts - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_enc = ID_W'(i);
            end
        end
    end

    // Set beats clear in the same cycle.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_set;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            irq_out      <= 1'b0;
            irq_id       <= '0;
            busy         <= 1'b0;
            claimed_id   <= '0;
            complete_err <= 1'b0;
        end else begin
            complete_err <= complete && !w_complete_ok;
            case (r_state)
                ST_IDLE: begin
                    if (w_claim_ok) begin
                        r_state    <= ST_SERVICE;
                        busy       <= 1'b1;
                        claimed_id <= irq_id;
                        irq_out    <= 1'b0;
                    end else begin
                        irq_out <= w_any;
                        irq_id  <= w_enc;
                    end
                end
                ST_SERVICE: begin
                    // irq_out stays low and irq_id holds; presentation resumes
                    // on the edge after returning to IDLE.
                    if (w_complete_ok) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/irq_pending_arbiter.md
IRQ_PENDING_ARBITER -- requirements
Module: irq_pending_arbiter

Interface
REQ-001 SHALL have parameter N_interrupts, default 32, meaning number of interrupt channels (2..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per request line (>=2).
REQ-003 SHALL have localparam ID_W = $clog2(N_interrupts), meaning channel ID width.
REQ-004 SHALL have port CLK, input, 1, the single clock; all state is rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port interrupt_requests, input, N_interrupts, raw asynchronous request lines.
REQ-007 SHALL have port interrupt_masks, input, N_interrupts, where 1 masks the channel and 0 enables it.
REQ-008 SHALL have port interrupt_edge_mode, input, N_interrupts, where 1 means rising-edge and 0 means level-high.
REQ-009 SHALL have port claim, input, 1, a single-cycle strobe that accepts the presented ID.
REQ-010 SHALL have port complete, input, 1, a single-cycle strobe that ends service.
REQ-011 SHALL have port complete_id, input, ID_W, the ID being completed.
REQ-012 SHALL have port irq_out, output, 1, registered "eligible interrupt presented".
REQ-013 SHALL have port irq_id, output, ID_W, the registered highest-priority eligible ID.
REQ-014 SHALL have port busy, output, 1, high while in SERVICE.
REQ-015 SHALL have port claimed_id, output, ID_W, the ID currently in service.
REQ-016 SHALL have port pending, output, N_interrupts, the raw pending register, unmasked.
REQ-017 SHALL have port complete_err, output, 1, a one-cycle pulse on an invalid complete.

Function
REQ-018 SHALL pass each request bit through a SYNC_STAGES flop chain; the last stage is "sync" and one further flop is "prev".
REQ-019 SHALL set pending[i] in edge mode when sync[i] & ~prev[i].
REQ-020 SHALL set pending[i] in level mode when sync[i]=1 and channel i is not in service.
REQ-021 SHALL clear pending[i] only by a claim accepted for ID i; a set condition in the same cycle wins, so pending stays 1.
REQ-022 SHALL leave masked channels' pending bits held; a mask only gates eligibility.
REQ-023 SHALL compute eligible = pending & ~interrupt_masks, with fixed priority where the lowest index wins.
REQ-024 SHALL use a two-state FSM: IDLE and SERVICE.
REQ-025 SHALL, in IDLE, register irq_out = |eligible and irq_id = encode(eligible) every cycle; irq_id=0 when none are eligible.
REQ-026 SHALL accept claim only in IDLE with irq_out=1: latch claimed_id=irq_id, clear pending[irq_id], and go to SERVICE next edge.
REQ-027 SHALL ignore claim in IDLE with irq_out=0, and ignore claim in SERVICE, with no state change.
REQ-028 SHALL, in SERVICE, force irq_out=0 and busy=1, with irq_id holding its last value.
REQ-029 SHALL, in SERVICE, treat complete with complete_id==claimed_id as returning to IDLE next edge, with irq_out re-evaluated the following edge.
REQ-030 SHALL, on complete with a mismatched ID or complete in IDLE, pulse complete_err for 1 cycle and leave state unchanged.
REQ-031 SHALL, when claim and complete arrive in the same cycle, evaluate against the current state only; no chained claim.
REQ-032 SHALL raise irq_out exactly SYNC_STAGES+2 edges after the first edge sampling a new request high, when idle, unmasked and highest priority.
REQ-033 SHALL reflect a mask change on irq_out/irq_id one edge later.
REQ-034 SHALL keep a new edge on the in-service channel in SERVICE pending, presented after completion.

Reset
REQ-035 SHALL, while rst=1, asynchronously clear all sync/prev flops, pending, FSM to IDLE, irq_out=0, irq_id=0, busy=0, claimed_id=0, complete_err=0.
REQ-036 SHALL abandon an in-progress service on reset mid-SERVICE, with no complete required after release.
REQ-037 SHALL NOT raise a spurious edge-mode pending on the first cycles after reset release for an input that was already high, because prev also resets to 0 and sync must fill first; an input high throughout reset sets pending once.

Verification (N_interrupts=8, SYNC_STAGES=2)
REQ-038 SHALL cover: edge mode on ch5, masks=0, pulse req[5] -> irq_out=1, irq_id=5 at edge 4; claim -> busy=1, pending[5]=0, claimed_id=5.
REQ-039 SHALL cover: ch2 and ch6 pending together -> irq_id=2; claim then complete(2) -> irq_id=6 two edges after complete.
REQ-040 SHALL cover: ch3 pending and mask[3]=1 -> irq_out=0, pending[3]=1; clear mask -> irq_out=1, irq_id=3 one edge later.
REQ-041 SHALL cover: level ch1 held high, claim, complete(1) -> pending[1] re-sets and irq_out=1, irq_id=1 again; complete(4) in SERVICE -> complete_err pulse, busy stays 1.
REQ-042 SHALL cover: in SERVICE on ch0, new edge on ch0 -> pending[0]=1, irq_out=0; complete(0) -> irq_out=1, irq_id=0.
REQ-043 SHALL cover: rst asserted mid-SERVICE between edges -> all outputs 0 immediately, without waiting for CLK.
